// File: rtl/alarm_clock_display.sv
// Alarm clock: HH:MM:SS timekeeping, an independently adjustable alarm with ring/stop/snooze
// handling, and a 4-digit multiplexed 7-segment driver with 12/24 h formatting and field blinking.
module alarm_clock_display #(
  parameter bit HOUR_12        = 1'b0,
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_MIN     = 5,
  parameter int ALARM_RST_HOUR = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sec_tick,
  input  logic       scan_tick,
  input  logic       en,
  input  logic       alarm_sel,
  input  logic       adjust_en_min,
  input  logic       adjust_en_hour,
  input  logic       updown,
  input  logic       alarm_arm,
  input  logic       snooze,
  input  logic       alarm_stop,
  output logic [6:0] segments,
  output logic       dp,
  output logic [3:0] anode_active,
  output logic       alarm_ring
);

  localparam logic [9:0] RING_LOAD   = 10'(RING_SECONDS);
  localparam logic [9:0] SNOOZE_LOAD = 10'(SNOOZE_MIN * 60);
  localparam logic [4:0] ALARM_RST_H = 5'(ALARM_RST_HOUR);

  typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} state_t;

  logic [5:0] sec_q, sec_d, min_q, min_d, alarm_min_q, alarm_min_d;
  logic [4:0] hour_q, hour_d, alarm_hour_q, alarm_hour_d;
  logic       blink_q, blink_d, match_q, match_d;
  logic [1:0] scan_q, scan_d;
  logic       adj_any;

  state_t     state_q;
  logic [9:0] cnt_q;
  logic       alarm_ring_q;

  function automatic logic [5:0] step60(input logic [5:0] v, input logic up);
    if (up) return (v == 6'd59) ? 6'd0 : v + 6'd1;
    return (v == 6'd0) ? 6'd59 : v - 6'd1;
  endfunction

  function automatic logic [4:0] step24(input logic [4:0] v, input logic up);
    if (up) return (v == 5'd23) ? 5'd0 : v + 5'd1;
    return (v == 5'd0) ? 5'd23 : v - 5'd1;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  always_comb begin
    sec_d        = sec_q;
    min_d        = min_q;
    hour_d       = hour_q;
    alarm_min_d  = alarm_min_q;
    alarm_hour_d = alarm_hour_q;
    adj_any      = adjust_en_min | adjust_en_hour;
    if (sec_tick) begin
      if (adj_any && !alarm_sel) begin
        sec_d = 6'd0;
        if (adjust_en_min) min_d = step60(min_q, updown);
        else               hour_d = step24(hour_q, updown);
      end else if (en) begin
        if (sec_q == 6'd59) begin
          sec_d = 6'd0;
          if (min_q == 6'd59) begin
            min_d  = 6'd0;
            hour_d = step24(hour_q, 1'b1);
          end else begin
            min_d = min_q + 6'd1;
          end
        end else begin
          sec_d = sec_q + 6'd1;
        end
      end
      if (adj_any && alarm_sel) begin
        if (adjust_en_min) alarm_min_d = step60(alarm_min_q, updown);
        else               alarm_hour_d = step24(alarm_hour_q, updown);
      end
    end
    // Only a real change of time counts, so a frozen clock sitting on the alarm time cannot re-trigger.
    match_d = sec_tick && alarm_arm && ({hour_d, min_d, sec_d} != {hour_q, min_q, sec_q}) &&
              (sec_d == 6'd0) && (min_d == alarm_min_q) && (hour_d == alarm_hour_q);
    blink_d = adj_any ? (blink_q ^ sec_tick) : 1'b1;
    scan_d  = scan_q + {1'b0, scan_tick};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sec_q        <= 6'd0;
      min_q        <= 6'd0;
      hour_q       <= 5'd0;
      alarm_min_q  <= 6'd0;
      alarm_hour_q <= ALARM_RST_H;
      blink_q      <= 1'b1;
      match_q      <= 1'b0;
      scan_q       <= 2'd0;
    end else begin
      sec_q        <= sec_d;
      min_q        <= min_d;
      hour_q       <= hour_d;
      alarm_min_q  <= alarm_min_d;
      alarm_hour_q <= alarm_hour_d;
      blink_q      <= blink_d;
      match_q      <= match_d;
      scan_q       <= scan_d;
    end
  end

  // One shared down-counter serves both ring duration and snooze length.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 10'd0;
      alarm_ring_q <= 1'b0;
    end else if (!alarm_arm) begin
      state_q      <= IDLE;
      alarm_ring_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (match_q) begin
            state_q      <= RINGING;
            cnt_q        <= RING_LOAD;
            alarm_ring_q <= 1'b1;
          end
        end
        RINGING: begin
          if (alarm_stop) begin
            state_q      <= IDLE;
            alarm_ring_q <= 1'b0;
          end else if (snooze) begin
            state_q      <= SNOOZED;
            cnt_q        <= SNOOZE_LOAD;
            alarm_ring_q <= 1'b0;
          end else if (sec_tick) begin
            if (cnt_q <= 10'd1) begin
              state_q      <= IDLE;
              alarm_ring_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q - 10'd1;
            end
          end
        end
        SNOOZED: begin
          if (alarm_stop) begin
            state_q <= IDLE;
          end else if (sec_tick) begin
            if (cnt_q <= 10'd1) begin
              state_q      <= RINGING;
              cnt_q        <= RING_LOAD;
              alarm_ring_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q - 10'd1;
            end
          end
        end
        default: begin
          state_q      <= IDLE;
          alarm_ring_q <= 1'b0;
        end
      endcase
    end
  end

  assign alarm_ring = alarm_ring_q;

  logic [5:0] disp_min;
  logic [4:0] disp_hour_raw, disp_hour;
  logic       pm;
  logic [3:0] digit;
  logic       blank;

  always_comb begin
    disp_min      = alarm_sel ? alarm_min_q : min_q;
    disp_hour_raw = alarm_sel ? alarm_hour_q : hour_q;
    pm            = 1'b0;
    disp_hour     = disp_hour_raw;
    if (HOUR_12) begin
      pm        = (disp_hour_raw >= 5'd12);
      disp_hour = pm ? disp_hour_raw - 5'd12 : disp_hour_raw;
      if (disp_hour == 5'd0) disp_hour = 5'd12;
    end
  end

  always_comb begin
    case (scan_q)
      2'd0:    digit = 4'(disp_min % 6'd10);
      2'd1:    digit = 4'(disp_min / 6'd10);
      2'd2:    digit = 4'(disp_hour % 5'd10);
      default: digit = 4'(disp_hour / 5'd10);
    endcase
    // scan_q[1]=0 selects the minute pair, so the blanked pair is the one matching adjust_en_min.
    blank = adj_any && !blink_q && (adjust_en_min == !scan_q[1]);
    if (HOUR_12 && (scan_q == 2'd3) && (digit == 4'd0)) blank = 1'b1;
    segments = blank ? 7'h7F : seg7(digit);
    case (scan_q)
      2'd0:    dp = ~pm;
      2'd2:    dp = sec_q[0] | alarm_sel;
      2'd3:    dp = ~alarm_arm;
      default: dp = 1'b1;
    endcase
  end

  assign anode_active = ~(4'b0001 << scan_q);

endmodule

// File: tb/tb_alarm_clock_display.sv
// Scoreboard bench: 24 h and 12 h instances share stimulus; a seconds-of-day reference model
// predicts every cycle's display and ring outputs, plus directed checks for the key scenarios.
module tb_alarm_clock_display;
  localparam int RING = 60;
  localparam int SNZ  = 5;
  localparam int ARH  = 6;

  logic clk = 1'b0;
  logic rst, sec_tick, scan_tick, en, alarm_sel, adjust_en_min, adjust_en_hour;
  logic updown, alarm_arm, snooze, alarm_stop;
  logic [6:0] seg24, seg12;
  logic       dp24, dp12, ring24, ring12;
  logic [3:0] an24, an12;

  always #5 clk = ~clk;

  alarm_clock_display #(.HOUR_12(1'b0), .RING_SECONDS(RING), .SNOOZE_MIN(SNZ), .ALARM_RST_HOUR(ARH)) dut24 (
    .clk(clk), .rst(rst), .sec_tick(sec_tick), .scan_tick(scan_tick), .en(en),
    .alarm_sel(alarm_sel), .adjust_en_min(adjust_en_min), .adjust_en_hour(adjust_en_hour),
    .updown(updown), .alarm_arm(alarm_arm), .snooze(snooze), .alarm_stop(alarm_stop),
    .segments(seg24), .dp(dp24), .anode_active(an24), .alarm_ring(ring24));

  alarm_clock_display #(.HOUR_12(1'b1), .RING_SECONDS(RING), .SNOOZE_MIN(SNZ), .ALARM_RST_HOUR(ARH)) dut12 (
    .clk(clk), .rst(rst), .sec_tick(sec_tick), .scan_tick(scan_tick), .en(en),
    .alarm_sel(alarm_sel), .adjust_en_min(adjust_en_min), .adjust_en_hour(adjust_en_hour),
    .updown(updown), .alarm_arm(alarm_arm), .snooze(snooze), .alarm_stop(alarm_stop),
    .segments(seg12), .dp(dp12), .anode_active(an12), .alarm_ring(ring12));

  typedef struct {
    logic [6:0] seg24;
    logic [6:0] seg12;
    logic       dp24;
    logic       dp12;
    logic [3:0] an;
    logic       ring;
    int         dkind;
    logic [6:0] dexp;
  } exp_t;

  exp_t  sb[$];
  string dn[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  // Reference model: time as seconds of day, alarm as minutes of day.
  int m_t, m_al, m_st, m_cnt, m_scan;
  bit m_match, m_blink;

  int         d_kind = 0;
  logic [6:0] d_exp  = 7'h00;
  string      d_name = "";

  function automatic void model_reset();
    m_t = 0; m_al = ARH * 60; m_st = 0; m_cnt = 0; m_scan = 0; m_match = 0; m_blink = 1;
  endfunction

  function automatic logic [6:0] seg_of(input int d);
    logic [6:0] tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return tbl[d];
  endfunction

  function automatic void exp_disp(input bit h12, output logic [6:0] seg, output logic dpo);
    int hh, mm, shown, dig;
    bit pm, blank;
    hh    = alarm_sel ? m_al / 60 : m_t / 3600;
    mm    = alarm_sel ? m_al % 60 : (m_t / 60) % 60;
    shown = h12 ? ((hh % 12 == 0) ? 12 : hh % 12) : hh;
    pm    = h12 && (hh >= 12);
    case (m_scan)
      0: dig = mm % 10;
      1: dig = mm / 10;
      2: dig = shown % 10;
      default: dig = shown / 10;
    endcase
    blank = (adjust_en_min || adjust_en_hour) && !m_blink &&
            ((adjust_en_min && m_scan < 2) || (!adjust_en_min && m_scan >= 2));
    if (h12 && m_scan == 3 && shown / 10 == 0) blank = 1;
    seg = blank ? 7'h7F : seg_of(dig);
    dpo = 1'b1;
    if (m_scan == 0 && pm) dpo = 1'b0;
    if (m_scan == 2 && (m_t % 2) == 0 && !alarm_sel) dpo = 1'b0;
    if (m_scan == 3 && alarm_arm) dpo = 1'b0;
  endfunction

  function automatic void model_update();
    int old_t, h, mi, d;
    bit adj;
    if (rst) begin
      model_reset();
      return;
    end
    if (!alarm_arm) m_st = 0;
    else begin
      case (m_st)
        0: if (m_match) begin m_st = 1; m_cnt = RING; end
        1: begin
          if (alarm_stop) m_st = 0;
          else if (snooze) begin m_st = 2; m_cnt = SNZ * 60; end
          else if (sec_tick) begin
            if (m_cnt <= 1) m_st = 0; else m_cnt--;
          end
        end
        default: begin
          if (alarm_stop) m_st = 0;
          else if (sec_tick) begin
            if (m_cnt <= 1) begin m_st = 1; m_cnt = RING; end else m_cnt--;
          end
        end
      endcase
    end
    adj = adjust_en_min || adjust_en_hour;
    d   = updown ? 1 : -1;
    m_match = 0;
    if (sec_tick) begin
      old_t = m_t;
      if (adj && !alarm_sel) begin
        h = m_t / 3600; mi = (m_t / 60) % 60;
        if (adjust_en_min) mi = (mi + d + 60) % 60; else h = (h + d + 24) % 24;
        m_t = h * 3600 + mi * 60;
      end else if (en) m_t = (m_t + 1) % 86400;
      m_match = alarm_arm && (m_t != old_t) && (m_t == m_al * 60);
      if (adj && alarm_sel) begin
        h = m_al / 60; mi = m_al % 60;
        if (adjust_en_min) mi = (mi + d + 60) % 60; else h = (h + d + 24) % 24;
        m_al = h * 60 + mi;
      end
    end
    if (adj) begin
      if (sec_tick) m_blink = !m_blink;
    end else m_blink = 1;
    if (scan_tick) m_scan = (m_scan + 1) % 4;
  endfunction

  function automatic void chk(input string nm, input logic [6:0] got, input logic [6:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", nm, $time, got, want);
  endfunction

  // Stimulus: predict this cycle's outputs into the scoreboard, then clock the model.
  task automatic step(input bit tk, input bit sc, input bit snz, input bit stp);
    exp_t e;
    logic [6:0] s24, s12;
    logic p24, p12;
    sec_tick = tk; scan_tick = sc; snooze = snz; alarm_stop = stp;
    exp_disp(1'b0, s24, p24);
    exp_disp(1'b1, s12, p12);
    e.seg24 = s24; e.seg12 = s12; e.dp24 = p24; e.dp12 = p12;
    e.an    = ~(4'b0001 << m_scan);
    e.ring  = (m_st == 1);
    e.dkind = d_kind; e.dexp = d_exp;
    sb.push_back(e);
    dn.push_back(d_name);
    d_kind = 0;
    @(posedge clk);
    model_update();
    #1;
    sec_tick = 0; scan_tick = 0; snooze = 0; alarm_stop = 0;
  endtask

  task automatic dexpect(input int k, input logic [6:0] v, input string nm);
    d_kind = k; d_exp = v; d_name = nm;
    step(0, 0, 0, 0);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
    end
  endtask

  task automatic adj(input bit is_min, input bit up, input int n);
    adjust_en_min = is_min; adjust_en_hour = !is_min; updown = up;
    ticks(n);
    adjust_en_min = 0; adjust_en_hour = 0;
    step(0, 0, 0, 0);
  endtask

  task automatic scan_to(input int k);
    while (m_scan != k) step(0, 1, 0, 0);
  endtask

  // Monitor: pops one prediction per cycle and compares on the falling edge.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e  = sb.pop_front();
        nm = dn.pop_front();
        chk("seg24", seg24, e.seg24);
        chk("seg12", seg12, e.seg12);
        chk("dp24", {6'b0, dp24}, {6'b0, e.dp24});
        chk("dp12", {6'b0, dp12}, {6'b0, e.dp12});
        chk("anode24", {3'b0, an24}, {3'b0, e.an});
        chk("anode12", {3'b0, an12}, {3'b0, e.an});
        chk("ring24", {6'b0, ring24}, {6'b0, e.ring});
        chk("ring12", {6'b0, ring12}, {6'b0, e.ring});
        case (e.dkind)
          1: chk(nm, seg24, e.dexp);
          2: chk(nm, seg12, e.dexp);
          3: chk(nm, {6'b0, dp12}, e.dexp);
          4: chk(nm, {6'b0, ring24}, e.dexp);
          5: chk(nm, {3'b0, an24}, e.dexp);
          6: chk(nm, {6'b0, dp24}, e.dexp);
          default: ;
        endcase
      end
    end
  end

  initial begin
    rst = 1; sec_tick = 0; scan_tick = 0; en = 1; alarm_sel = 0; adjust_en_min = 0;
    adjust_en_hour = 0; updown = 1; alarm_arm = 0; snooze = 0; alarm_stop = 0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    rst = 0;

    dexpect(5, 7'h0E, "reset_anode");
    dexpect(1, 7'h40, "reset_min_ones");
    dexpect(6, 7'h01, "reset_dp");
    dexpect(4, 7'h00, "reset_ring");

    ticks(60);
    dexpect(1, 7'h79, "count_00_01_00");

    adj(0, 0, 1);
    adj(1, 0, 2);
    ticks(59);
    dexpect(1, 7'h10, "at_23_59_59");
    ticks(1);
    dexpect(1, 7'h40, "wrap_00_00_00");

    alarm_sel = 1; adjust_en_min = 1; updown = 0;
    step(1, 0, 0, 0);
    dexpect(1, 7'h7F, "alarm_min_blank");
    step(1, 0, 0, 0);
    dexpect(1, 7'h00, "alarm_min_58");
    updown = 1;
    ticks(2);
    adjust_en_min = 0; alarm_sel = 0;
    step(0, 0, 0, 0);

    adj(0, 1, 5);
    adj(1, 0, 1);
    ticks(59);
    alarm_arm = 1;
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    dexpect(4, 7'h01, "ring_on");
    ticks(59);
    dexpect(4, 7'h01, "ring_before_timeout");
    ticks(1);
    dexpect(4, 7'h00, "ring_timeout");

    adj(1, 0, 1);
    dexpect(4, 7'h01, "ring_again");
    step(0, 0, 1, 0);
    dexpect(4, 7'h00, "snoozed");
    ticks(299);
    dexpect(4, 7'h00, "snooze_299");
    ticks(1);
    dexpect(4, 7'h01, "snooze_expired");
    step(0, 0, 1, 1);
    dexpect(4, 7'h00, "stop_beats_snooze");
    ticks(301);
    dexpect(4, 7'h00, "stays_idle");

    adjust_en_min = 1; updown = 0;
    for (int i = 0; i < 70 && (m_t / 60) % 60 != 0; i++) begin
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
    end
    adjust_en_min = 0;
    step(0, 1, 0, 0);
    dexpect(4, 7'h01, "ring_before_rst");
    rst = 1;
    step(0, 0, 0, 0);
    rst = 0;
    dexpect(4, 7'h00, "rst_ring");
    dexpect(5, 7'h0E, "rst_anode");
    dexpect(1, 7'h40, "rst_time");

    alarm_arm = 0;
    adj(0, 1, 13);
    adj(1, 1, 7);
    scan_to(0);
    dexpect(2, 7'h78, "h12_1307_d0");
    dexpect(3, 7'h00, "h12_pm_dp");
    scan_to(1);
    dexpect(2, 7'h40, "h12_1307_d1");
    dexpect(5, 7'h0D, "anode_d1");
    scan_to(2);
    dexpect(2, 7'h79, "h12_1307_d2");
    dexpect(5, 7'h0B, "anode_d2");
    scan_to(3);
    dexpect(2, 7'h7F, "h12_tens_blank");
    dexpect(5, 7'h07, "anode_d3");
    dexpect(1, 7'h79, "h24_1307_d3");

    adj(0, 1, 11);
    adj(1, 1, 23);
    scan_to(0);
    dexpect(2, 7'h40, "h12_0030_d0");
    dexpect(3, 7'h01, "h12_am_dp");
    scan_to(1);
    dexpect(2, 7'h30, "h12_0030_d1");
    scan_to(2);
    dexpect(2, 7'h24, "h12_0030_d2");
    scan_to(3);
    dexpect(2, 7'h79, "h12_0030_d3");
    dexpect(1, 7'h40, "h24_leading_zero");

    for (int i = 0; i < 3000; i++) begin
      if (i % 40 == 0) begin
        int r;
        r = int'($urandom_range(0, 5));
        en             = ($urandom_range(0, 7) != 0);
        alarm_sel      = ($urandom_range(0, 3) == 0);
        adjust_en_min  = (r == 1 || r == 3);
        adjust_en_hour = (r == 2 || r == 3);
        updown         = 1'($urandom_range(0, 1));
        alarm_arm      = ($urandom_range(0, 3) != 0);
      end
      rst = ($urandom_range(0, 999) == 0);
      step($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 29) == 0, $urandom_range(0, 49) == 0);
      rst = 0;
    end

    repeat (3) @(posedge clk);
    n_checks++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending expected 0", sb.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
